// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx - device-side PS/2 keyboard frame generator.
//
// Scan-code bytes arrive over a valid/ready handshake into a small FIFO and
// are serialised one at a time as 11-bit PS/2 frames (start, 8 data bits LSB
// first, odd parity, stop). ps2_data only changes while ps2_clk is high, so
// the receiver can sample on the falling edge of ps2_clk.
//
// Parameters:
//   HALF_CYC - system clocks per PS/2 clock half-period (>= 2)
//   GAP_CYC  - idle system clocks between frames, both lines high (>= 1)
//   DEPTH    - FIFO depth in bytes, power of two (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_data    in   scan-code byte to send
//   in_valid   in   in_data valid this cycle
//   in_ready   out  FIFO not full; byte taken when in_valid & in_ready
//   ps2_clk    out  PS/2 clock to receiver, idles high
//   ps2_data   out  PS/2 data to receiver, idles high
//   busy       out  frame in progress or FIFO non-empty
//   sent_pulse out  one-cycle pulse after the stop bit's low phase ends
module ps2_kbd_tx #(
  parameter int HALF_CYC = 4,
  parameter int GAP_CYC  = 8,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ps2_clk,
  output logic       ps2_data,
  output logic       busy,
  output logic       sent_pulse
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (HALF_CYC > GAP_CYC) ? HALF_CYC : GAP_CYC;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_CYC - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYC - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      bit_q, bit_d;
  logic [10:0]     shreg_q, shreg_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      mem [DEPTH];

  logic            ps2_clk_q, ps2_clk_d;
  logic            ps2_data_q, ps2_data_d;
  logic            in_ready_q, in_ready_d;
  logic            busy_q, busy_d;
  logic            sent_q, sent_d;

  logic            push;
  logic            pop;

  // Frame bit 0 goes out first: start, d[0..7], odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + TW'(1);
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    sent_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pop) begin
          shreg_d = make_frame(mem[rd_ptr_q]);
          bit_d   = '0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          if (bit_q < 4'd10) begin
            // Advance to the next bit as the clock goes high again, so data
            // only ever changes during the high phase.
            bit_d   = bit_q + 4'd1;
            shreg_d = {1'b1, shreg_q[10:1]};
            state_d = S_HIGH;
          end else begin
            sent_d  = 1'b1;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe without an extra cycle of lag.
  always_comb begin
    ps2_clk_d  = (state_d != S_LOW);
    ps2_data_d = ((state_d == S_HIGH) || (state_d == S_LOW)) ? shreg_d[0] : 1'b1;
    busy_d     = (state_d != S_IDLE) || (count_d != '0);
    in_ready_d = (count_d != FULL_CNT);
  end

  // ---- control registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      bit_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ps2_clk_q  <= ps2_clk_d;
      ps2_data_q <= ps2_data_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
    end
  end

  // ---- data registers (contents are don't-care until loaded) ----
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;
  assign busy       = busy_q;
  assign sent_pulse = sent_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a frame-timeline reference model is
// compared against all outputs every cycle, and a PS/2 receiver decodes the
// frames for literal and scoreboard checks.
module tb_ps2_kbd_tx;

  localparam int HALF      = 4;
  localparam int GAP       = 8;
  localparam int DEP       = 8;
  localparam int FRAME_LEN = 22 * HALF;
  localparam int LAST      = FRAME_LEN + GAP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic       sent_pulse;

  ps2_kbd_tx #(
    .HALF_CYC(HALF),
    .GAP_CYC (GAP),
    .DEPTH   (DEP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .busy      (busy),
    .sent_pulse(sent_pulse)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h), expected %0d (0x%0h)",
               nm, cyc, act, act, exp, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d: bound expired", nm, cyc);
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d, 1'b0};
  endfunction

  // Reference model: t is the cycle offset inside the current frame
  // (0 = first high phase of the start bit, LAST = the idle cycle that
  // follows the gap), -1 when nothing is being sent.
  logic [7:0]  mq[$];
  int          t = -1;
  logic [10:0] cur_fr = '0;
  bit          model_on = 1'b0;
  bit          m_rst = 1'b0;
  int          last_acc = 0;
  logic        e_clk = 1'b1, e_data = 1'b1, e_ready = 1'b1, e_busy = 1'b0, e_pulse = 1'b0;

  always @(posedge clk) begin
    bit acc;
    cyc++;
    if (rst) begin
      mq.delete();
      t        = -1;
      m_rst    = 1'b1;
      model_on = 1'b1;
      e_clk = 1'b1; e_data = 1'b1; e_ready = 1'b1; e_busy = 1'b0; e_pulse = 1'b0;
    end else begin
      m_rst = 1'b0;
      acc = in_valid && (mq.size() < DEP);
      if (t == -1 || t == LAST) begin
        if (mq.size() > 0) begin
          cur_fr = frame_of(mq.pop_front());
          t = 0;
        end else begin
          t = -1;
        end
      end else begin
        t++;
      end
      if (acc) begin
        mq.push_back(in_data);
        last_acc = cyc;
      end
      if (t >= 0 && t < FRAME_LEN) begin
        e_clk  = (t % (2 * HALF)) < HALF;
        e_data = cur_fr[t / (2 * HALF)];
      end else begin
        e_clk  = 1'b1;
        e_data = 1'b1;
      end
      e_pulse = (t == FRAME_LEN);
      e_busy  = (t >= 0 && t < LAST) || (mq.size() > 0);
      e_ready = (mq.size() < DEP);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("ps2_clk",    int'(ps2_clk),    int'(e_clk));
      chk("ps2_data",   int'(ps2_data),   int'(e_data));
      chk("in_ready",   int'(in_ready),   int'(e_ready));
      chk("busy",       int'(busy),       int'(e_busy));
      chk("sent_pulse", int'(sent_pulse), int'(e_pulse));
    end
  end

  // PS/2 receiver: samples data on ps2_clk falling edges.
  logic [10:0] rx_frames[$];
  int          starts[$];
  logic [10:0] part = '0;
  int          part_n = 0;
  int          falls = 0;
  int          pulses = 0;
  int          lo_n = 0;
  logic        prev_clk = 1'b1;

  always @(negedge clk) begin
    if (model_on) begin
      if (m_rst) begin
        part_n = 0;
        lo_n   = 0;
      end else begin
        if (sent_pulse) pulses++;
        if (prev_clk && !ps2_clk) begin
          falls++;
          if (part_n == 0) starts.push_back(cyc);
          part[part_n] = ps2_data;
          part_n++;
          if (part_n == 11) begin
            rx_frames.push_back(part);
            part_n = 0;
          end
        end
        if (!ps2_clk) begin
          lo_n++;
        end else if (!prev_clk) begin
          chk("low_width", lo_n, HALF);
          lo_n = 0;
        end
      end
      prev_clk = ps2_clk;
    end
  end

  logic [7:0] sent_q[$];

  function automatic int fr(input int i);
    return (i < rx_frames.size()) ? int'(rx_frames[i]) : -1;
  endfunction

  function automatic int st(input int i);
    return (i < starts.size()) ? starts[i] : -100000;
  endfunction

  task automatic clear_rx();
    rx_frames.delete();
    starts.delete();
    sent_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte is taken.
  task automatic push(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      fail_now("push_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      sent_q.push_back(b);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (n >= bound) fail_now("wait_idle_timeout");
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int p0;
    int n;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ps2_clk",  int'(ps2_clk),  1);
    chk("reset_ps2_data", int'(ps2_data), 1);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_busy",     int'(busy),     0);

    // Idle after reset.
    f0 = falls;
    repeat (50) @(negedge clk);
    chk("idle_falls", falls - f0, 0);
    chk("idle_busy", int'(busy), 0);

    // Single 0x1C.
    clear_rx();
    p0 = pulses;
    push(8'h1C);
    wait_idle(400);
    chk("1C_nframes", rx_frames.size(), 1);
    chk("1C_frame", fr(0), 'h438);
    chk("1C_pulses", pulses - p0, 1);
    chk("1C_latency", st(0) - last_acc, 1 + HALF);

    // 0xF0 then 0x1C back to back.
    clear_rx();
    push(8'hF0);
    push(8'h1C);
    wait_idle(600);
    chk("F0_1C_nframes", rx_frames.size(), 2);
    chk("F0_frame", fr(0), 'h7E0);
    chk("1C_second_frame", fr(1), 'h438);
    chk("frame_period", st(1) - st(0), 97);

    // 0x00.
    clear_rx();
    push(8'h00);
    wait_idle(400);
    chk("00_frame", fr(0), 'h600);

    // Fill the FIFO with 9 distinct bytes.
    clear_rx();
    for (int i = 0; i < 9; i++) push(8'hA0 + 8'(i));
    chk("fill_in_ready_low", int'(in_ready), 0);
    wait_idle(9 * 97 + 300);
    chk("fill_nframes", rx_frames.size(), 9);
    for (int i = 0; i < 9; i++) chk("fill_frame", fr(i), int'(frame_of(8'hA0 + 8'(i))));

    // Random bytes with random gaps.
    clear_rx();
    repeat (24) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'($urandom_range(0, 255)));
    end
    wait_idle(24 * 97 + 500);
    chk("rand_nframes", rx_frames.size(), sent_q.size());
    for (int i = 0; i < sent_q.size(); i++) chk("rand_frame", fr(i), int'(frame_of(sent_q[i])));

    // Reset during the low phase of bit 4 with 3 bytes queued.
    clear_rx();
    part_n = 0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    n = 0;
    while (part_n != 5 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 1000) fail_now("bit4_wait_timeout");
    chk("pre_rst_ps2_clk_low", int'(ps2_clk), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ps2_clk",  int'(ps2_clk),  1);
    chk("rst_mid_ps2_data", int'(ps2_data), 1);
    chk("rst_mid_busy",     int'(busy),     0);
    chk("rst_mid_in_ready", int'(in_ready), 1);
    clear_rx();
    f0 = falls;
    repeat (300) @(negedge clk);
    chk("post_rst_falls", falls - f0, 0);
    chk("post_rst_nframes", rx_frames.size(), 0);
    push(8'h1C);
    wait_idle(400);
    chk("post_rst_nframes_1C", rx_frames.size(), 1);
    chk("post_rst_1C_frame", fr(0), 'h438);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
